// File: rtl/sub_bytes_iterative.sv
// rtl/sub_bytes_iterative.sv - multi-cycle AES SubBytes, LANES bytes per cycle through a shared S-box bank
// Optional InvSubBytes support under `SUB_BYTES_INVERSE_EN (adds the inverse port).
module sub_bytes_iterative #(
  parameter int LANES = 4
) (
`ifdef SUB_BYTES_INVERSE_EN
  input  logic         inverse,
`endif
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out
);

  localparam int N  = 16 / LANES;
  localparam int LW = 8 * LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("sub_bytes_iterative: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    // Entry b sits at bits [2047-8b -: 8], i.e. index {~b, 3'b111}.
    return SBOX_FWD[{~b, 3'b111} -: 8];
  endfunction

`ifdef SUB_BYTES_INVERSE_EN
  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return SBOX_INV[{~b, 3'b111} -: 8];
  endfunction
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [127:0]    work;
  logic [127:0]    work_sub;
  logic [LW-1:0]   sel_chunk;
  logic [LW-1:0]   sub_chunk;
  logic            ready_en;
  logic            accept;
`ifdef SUB_BYTES_INVERSE_EN
  logic            inv_q;
`endif

  // ready_en keeps in_ready low while reset is held and for the first edge after it.
  assign in_ready = ready_en & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept   = in_valid & in_ready;
  assign out      = work;

  // Chunk k holds bytes [k*LANES +: LANES]; byte 0 is the most significant byte.
  always_comb begin
    sel_chunk = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(cnt) == k) sel_chunk = work[128-LW*(k+1) +: LW];
    end
  end

  always_comb begin
    work_sub = work;
    for (int k = 0; k < N; k++) begin
      if (int'(cnt) == k) work_sub[128-LW*(k+1) +: LW] = sub_chunk;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [7:0] b;
    assign b = sel_chunk[LW-1-8*g -: 8];
`ifdef SUB_BYTES_INVERSE_EN
    assign sub_chunk[LW-1-8*g -: 8] = inv_q ? sbox_inv(b) : sbox_fwd(b);
`else
    assign sub_chunk[LW-1-8*g -: 8] = sbox_fwd(b);
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      out_valid <= 1'b0;
      ready_en  <= 1'b0;
`ifdef SUB_BYTES_INVERSE_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      ready_en <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= BUSY;
            work  <= in;
            cnt   <= '0;
`ifdef SUB_BYTES_INVERSE_EN
            inv_q <= inverse;
`endif
          end
        end
        BUSY: begin
          work <= work_sub;
          if (cnt == CW'(N - 1)) begin
            cnt       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (accept) begin
              state <= BUSY;
              work  <= in;
              cnt   <= '0;
`ifdef SUB_BYTES_INVERSE_EN
              inv_q <= inverse;
`endif
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_iterative.sv
// tb/tb_sub_bytes_iterative.sv - directed scoreboard bench for sub_bytes_iterative
module tb_sub_bytes_iterative;

  localparam logic [127:0] VEC2_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] VEC2_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ALL_00   = 128'h0;
  localparam logic [127:0] ALL_63   = {16{8'h63}};
  localparam logic [127:0] ALL_53   = {16{8'h53}};
  localparam logic [127:0] ALL_ED   = {16{8'hed}};

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_st = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_st;
  logic         inverse = 1'b0;

  logic         sw_valid = 1'b0;
  logic [127:0] sw_in = '0;
  logic [2:0]   sw_ready;
  logic [2:0]   sw_ovalid;
  logic [127:0] sw_out [3];

  int tests = 0;
  int fails = 0;
  logic [127:0] exp_q [$];

  always #5 clock = ~clock;

  sub_bytes_iterative #(.LANES(4)) dut (
`ifdef SUB_BYTES_INVERSE_EN
    .inverse(inverse),
`endif
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in(in_st),
    .out_valid(out_valid), .out_ready(out_ready), .out(out_st)
  );

  sub_bytes_iterative #(.LANES(1)) u_l1 (
`ifdef SUB_BYTES_INVERSE_EN
    .inverse(inverse),
`endif
    .clock(clock), .reset_n(reset_n), .in_valid(sw_valid), .in_ready(sw_ready[0]), .in(sw_in),
    .out_valid(sw_ovalid[0]), .out_ready(1'b0), .out(sw_out[0])
  );

  sub_bytes_iterative #(.LANES(2)) u_l2 (
`ifdef SUB_BYTES_INVERSE_EN
    .inverse(inverse),
`endif
    .clock(clock), .reset_n(reset_n), .in_valid(sw_valid), .in_ready(sw_ready[1]), .in(sw_in),
    .out_valid(sw_ovalid[1]), .out_ready(1'b0), .out(sw_out[1])
  );

  sub_bytes_iterative #(.LANES(16)) u_l16 (
`ifdef SUB_BYTES_INVERSE_EN
    .inverse(inverse),
`endif
    .clock(clock), .reset_n(reset_n), .in_valid(sw_valid), .in_ready(sw_ready[2]), .in(sw_in),
    .out_valid(sw_ovalid[2]), .out_ready(1'b0), .out(sw_out[2])
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a state, wait (bounded) for in_ready, accept on the next edge.
  task automatic send(input logic [127:0] v, input logic [127:0] e, input bit push);
    int n = 0;
    in_st = v;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(posedge clock); #1; n++;
    end
    chk("send_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clock);
    if (push) exp_q.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    int lat = 0;
    logic [127:0] e;
    do begin
      @(posedge clock); #1; lat++;
    end while (!out_valid && lat < 50);
    chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    chk({tag, "_data"}, out_st, e);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk({tag, "_drained"}, {127'd0, out_valid}, 128'd0);
  endtask

  initial begin
    logic [127:0] held;
    int first [3];

    // 1: reset held with in_valid asserted
    in_st = VEC2_IN;
    in_valid = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out", out_st, ALL_00);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
    reset_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    chk("post_rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("post_rst_out_valid", {127'd0, out_valid}, 128'd0);

    // 2: FIPS-197 Appendix B round 1
    send(VEC2_IN, VEC2_OUT, 1'b1);
    wait_out("fips", 4);

    // 3: backpressure then same-cycle accept
    held = out_st;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      chk("bp_out_stable", out_st, held);
      chk("bp_out_valid", {127'd0, out_valid}, 128'd1);
      chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
    end
    in_st = ALL_00;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clock);
    exp_q.push_back(ALL_63);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_busy_out_valid", {127'd0, out_valid}, 128'd0);
    wait_out("zero", 4);
    consume("zero");

    // 4: reset in the middle of BUSY discards the state
    send(VEC2_IN, VEC2_OUT, 1'b0);
    repeat (2) begin
      @(posedge clock); #1;
    end
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("midrst_out", out_st, ALL_00);
    chk("midrst_in_ready", {127'd0, in_ready}, 128'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    send(ALL_53, ALL_ED, 1'b1);
    wait_out("post_rst", 4);
    consume("post_rst");

    // 5: LANES sweep with vector 2
    sw_in = VEC2_IN;
    sw_valid = 1'b1;
    #1;
    chk("sweep_ready", {125'd0, sw_ready}, 128'd7);
    @(posedge clock); #1;
    sw_valid = 1'b0;
    first = '{-1, -1, -1};
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock); #1;
      for (int i = 0; i < 3; i++) if (first[i] < 0 && sw_ovalid[i]) first[i] = c;
    end
    chk("sweep_lat_l1", 128'(first[0]), 128'd16);
    chk("sweep_lat_l2", 128'(first[1]), 128'd8);
    chk("sweep_lat_l16", 128'(first[2]), 128'd1);
    chk("sweep_out_l1", sw_out[0], VEC2_OUT);
    chk("sweep_out_l2", sw_out[1], VEC2_OUT);
    chk("sweep_out_l16", sw_out[2], VEC2_OUT);

`ifdef SUB_BYTES_INVERSE_EN
    // 6: inverse table
    inverse = 1'b1;
    send(VEC2_OUT, VEC2_IN, 1'b1);
    inverse = 1'b0;
    wait_out("inv_fips", 4);
    consume("inv_fips");
    inverse = 1'b1;
    send(ALL_63, ALL_00, 1'b1);
    inverse = 1'b0;
    wait_out("inv_63", 4);
    consume("inv_63");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
